// File: rtl/spi_slave.sv
// SPI mode-0 slave that decodes a cmd/addr/payload frame into parallel fields.
// Every SPI input is resynchronised into sysclk, and sclk edges are detected
// on the synchronised copy. For a read command the slave returns i_tx_payload
// on miso while the master is clocking in the payload field.
module spi_slave #(
   parameter int unsigned CMD_BITS     = 4,
   parameter int unsigned ADDR_BITS    = 4,
   parameter int unsigned PAYLOAD_BITS = 8,
   parameter int unsigned FRAME_BITS   = CMD_BITS + ADDR_BITS + PAYLOAD_BITS,
   parameter int unsigned CMD_NOP      = 0,
   parameter int unsigned CMD_LED_SET  = 1,
   parameter int unsigned CMD_LED_READ = 2,
   parameter int unsigned PAYLOAD_NONE = 0
) (
   input  logic                    sysclk,
   input  logic                    rst_n,
   input  logic                    sclk,
   input  logic                    cs,
   input  logic                    mosi,
   input  logic [PAYLOAD_BITS-1:0] i_tx_payload,
   output logic                    miso,
   output logic [CMD_BITS-1:0]     o_cmd,
   output logic [ADDR_BITS-1:0]    o_addr,
   output logic [PAYLOAD_BITS-1:0] o_payload,
   output logic                    rx_dv,
   output logic                    rd_bypass,
   output logic                    rx_addr_dv,
   output logic [FRAME_BITS-1:0]   o_shift_reg_debug,
   output logic                    o_serial_debug,
   output logic [4:0]              o_bit_rx_cnt_debug,
   output logic [1:0]              o_debug_stage
);

   // Command codes must be distinct, otherwise a read cannot be told apart.
   if (CMD_LED_READ == CMD_LED_SET || CMD_LED_READ == CMD_NOP || CMD_LED_SET == CMD_NOP)
   begin : g_bad_cmd_codes
      $error("spi_slave: command codes must be distinct");
   end

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCmdAddr = 2'd1,
      StPayload = 2'd2,
      StDone    = 2'd3
   } state_t;

   localparam logic [4:0] HdrBits   = 5'(CMD_BITS + ADDR_BITS);
   localparam logic [4:0] FrameBits = 5'(FRAME_BITS);

   // Synchroniser and edge-detect state
   logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
   logic cs_meta_q, cs_sync_q;
   logic mosi_meta_q, mosi_sync_q;
   logic sclk_rise, sclk_fall;

   // Cycles since reset release; the cs synchroniser holds its reset value until 2
   logic [1:0] settle_q;
   // Set once a genuine cs-high has been seen; a frame may only start when armed
   logic       armed_q;

   state_t                  state_q;
   logic [FRAME_BITS-1:0]   shift_q;
   logic [FRAME_BITS-1:0]   shift_nxt;
   logic [4:0]              bit_cnt_q;
   logic [PAYLOAD_BITS-1:0] tx_q;
   logic                    tx_load_q;
   logic                    miso_q;
   logic [CMD_BITS-1:0]     cmd_q;
   logic [ADDR_BITS-1:0]    addr_q;
   logic [PAYLOAD_BITS-1:0] payload_q;
   logic                    rx_dv_q;
   logic                    rd_bypass_q;
   logic                    rx_addr_dv_q;

   assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
   assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
   assign shift_nxt = {shift_q[FRAME_BITS-2:0], mosi_sync_q};

   // Two-flop synchronisers for the SPI pins plus the sclk edge-detect delay
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_meta_q <= 1'b0;
         sclk_sync_q <= 1'b0;
         sclk_prev_q <= 1'b0;
         cs_meta_q   <= 1'b1;
         cs_sync_q   <= 1'b1;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
      end else begin
         sclk_meta_q <= sclk;
         sclk_sync_q <= sclk_meta_q;
         sclk_prev_q <= sclk_sync_q;
         cs_meta_q   <= cs;
         cs_sync_q   <= cs_meta_q;
         mosi_meta_q <= mosi;
         mosi_sync_q <= mosi_meta_q;
      end
   end

   // Count out the synchroniser flush after reset so its reset value is not taken as cs-high
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         settle_q <= 2'd0;
      end else if (settle_q != 2'd2) begin
         settle_q <= settle_q + 2'd1;
      end
   end

   // Frame FSM: shifts mosi in, latches decoded fields and drives miso for reads
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         armed_q      <= 1'b0;
         shift_q      <= '0;
         bit_cnt_q    <= 5'd0;
         tx_q         <= '0;
         tx_load_q    <= 1'b0;
         miso_q       <= 1'b0;
         cmd_q        <= CMD_BITS'(CMD_NOP);
         addr_q       <= '0;
         payload_q    <= PAYLOAD_BITS'(PAYLOAD_NONE);
         rx_dv_q      <= 1'b0;
         rd_bypass_q  <= 1'b0;
         rx_addr_dv_q <= 1'b0;
      end else begin
         rx_dv_q <= 1'b0;
         if (cs_sync_q) begin
            // Deselect ends or aborts any frame
            state_q      <= StIdle;
            armed_q      <= (settle_q == 2'd2);
            bit_cnt_q    <= 5'd0;
            tx_load_q    <= 1'b0;
            miso_q       <= 1'b0;
            rd_bypass_q  <= 1'b0;
            rx_addr_dv_q <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (armed_q) begin
                     state_q   <= StCmdAddr;
                     armed_q   <= 1'b0;
                     shift_q   <= '0;
                     bit_cnt_q <= 5'd0;
                  end
               end
               StCmdAddr: begin
                  if (sclk_rise) begin
                     shift_q   <= shift_nxt;
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                     if (bit_cnt_q + 5'd1 == HdrBits) begin
                        state_q      <= StPayload;
                        cmd_q        <= shift_nxt[CMD_BITS+ADDR_BITS-1 -: CMD_BITS];
                        addr_q       <= shift_nxt[ADDR_BITS-1:0];
                        rx_addr_dv_q <= 1'b1;
                        rd_bypass_q  <= (shift_nxt[CMD_BITS+ADDR_BITS-1 -: CMD_BITS]
                                         == CMD_BITS'(CMD_LED_READ));
                        tx_load_q    <= (shift_nxt[CMD_BITS+ADDR_BITS-1 -: CMD_BITS]
                                         == CMD_BITS'(CMD_LED_READ));
                     end
                  end
               end
               StPayload: begin
                  // Load one cycle after o_addr updates so upstream can decode the new address
                  if (tx_load_q) begin
                     tx_q      <= i_tx_payload;
                     tx_load_q <= 1'b0;
                  end else if (sclk_fall && rd_bypass_q) begin
                     miso_q <= tx_q[PAYLOAD_BITS-1];
                     tx_q   <= {tx_q[PAYLOAD_BITS-2:0], 1'b0};
                  end
                  if (sclk_rise) begin
                     shift_q   <= shift_nxt;
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                     if (bit_cnt_q + 5'd1 == FrameBits) begin
                        state_q   <= StDone;
                        payload_q <= shift_nxt[PAYLOAD_BITS-1:0];
                        rx_dv_q   <= 1'b1;
                        miso_q    <= 1'b0;
                     end
                  end
               end
               StDone: begin
                  // Extra bits in this cs-low period are ignored
                  miso_q <= 1'b0;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign miso               = miso_q;
   assign o_cmd              = cmd_q;
   assign o_addr             = addr_q;
   assign o_payload          = payload_q;
   assign rx_dv              = rx_dv_q;
   assign rd_bypass          = rd_bypass_q;
   assign rx_addr_dv         = rx_addr_dv_q;
   assign o_shift_reg_debug  = shift_q;
   assign o_serial_debug     = mosi_sync_q;
   assign o_bit_rx_cnt_debug = bit_cnt_q;
   assign o_debug_stage      = state_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: mode-0 master model, one task per scenario.
module tb_spi_slave;

   localparam int HALF = 80;  // sclk half period; sysclk period is 10

   logic        sysclk = 1'b0;
   logic        rst_n  = 1'b0;
   logic        sclk   = 1'b0;
   logic        cs     = 1'b1;
   logic        mosi   = 1'b0;
   logic [7:0]  i_tx_payload;
   logic        miso;
   logic [3:0]  o_cmd;
   logic [3:0]  o_addr;
   logic [7:0]  o_payload;
   logic        rx_dv;
   logic        rd_bypass;
   logic        rx_addr_dv;
   logic [15:0] o_shift_reg_debug;
   logic        o_serial_debug;
   logic [4:0]  o_bit_rx_cnt_debug;
   logic [1:0]  o_debug_stage;

   int n_cmp = 0;
   int n_bad = 0;
   int dv_cnt = 0;
   logic [15:0] miso_cap;

   always #5 sysclk = ~sysclk;

   // Upstream register file: read data depends combinationally on the decoded address
   assign i_tx_payload = (o_addr == 4'd5) ? 8'h3C : 8'h00;

   always @(negedge sysclk) if (rx_dv) dv_cnt++;

   spi_slave dut (
      .sysclk             (sysclk),
      .rst_n              (rst_n),
      .sclk               (sclk),
      .cs                 (cs),
      .mosi               (mosi),
      .i_tx_payload       (i_tx_payload),
      .miso               (miso),
      .o_cmd              (o_cmd),
      .o_addr             (o_addr),
      .o_payload          (o_payload),
      .rx_dv              (rx_dv),
      .rd_bypass          (rd_bypass),
      .rx_addr_dv         (rx_addr_dv),
      .o_shift_reg_debug  (o_shift_reg_debug),
      .o_serial_debug     (o_serial_debug),
      .o_bit_rx_cnt_debug (o_bit_rx_cnt_debug),
      .o_debug_stage      (o_debug_stage)
   );

   // Clock out bits [first, first+n) of a frame, MSB first; capture miso at each rising edge
   task automatic clock_bits(input logic [15:0] data, input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         mosi = data[15-i];
         #HALF;
         sclk = 1'b1;
         miso_cap[15-i] = miso;
         #HALF;
         sclk = 1'b0;
      end
   endtask

   task automatic run_frame(input logic [15:0] data);
      cs = 1'b0;
      #HALF;
      clock_bits(data, 0, 16);
      #HALF;
      cs = 1'b1;
      #100;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #50;
      n_cmp++;
      if ({o_cmd, o_addr, o_payload, rx_dv, rd_bypass, rx_addr_dv} !== 19'd0) begin
         $display("FAIL reset_fields: got %h want 0",
                  {o_cmd, o_addr, o_payload, rx_dv, rd_bypass, rx_addr_dv});
         n_bad++;
      end
      n_cmp++;
      if ({o_shift_reg_debug, o_serial_debug, o_bit_rx_cnt_debug} !== 22'd0) begin
         $display("FAIL reset_debug: got %h want 0",
                  {o_shift_reg_debug, o_serial_debug, o_bit_rx_cnt_debug});
         n_bad++;
      end
      n_cmp++;
      if (o_debug_stage !== 2'd0 || miso !== 1'b0) begin
         $display("FAIL reset_stage_miso: got stage=%0d miso=%b want 0/0", o_debug_stage, miso);
         n_bad++;
      end
      rst_n = 1'b1;
      #100;
   endtask

   task automatic test_write();
      int dv0 = dv_cnt;
      int rd_hi = 0;
      fork
         run_frame({4'd1, 4'd3, 8'hA4});
         repeat (350) begin
            @(negedge sysclk);
            if (rd_bypass) rd_hi++;
         end
      join
      n_cmp++;
      if (dv_cnt - dv0 !== 1) begin
         $display("FAIL write_dv_count: got %0d want 1", dv_cnt - dv0); n_bad++;
      end
      n_cmp++;
      if ({o_cmd, o_addr, o_payload} !== {4'd1, 4'd3, 8'hA4}) begin
         $display("FAIL write_fields: got %h want 13a4", {o_cmd, o_addr, o_payload}); n_bad++;
      end
      n_cmp++;
      if (rd_hi !== 0 || miso_cap !== 16'h0000) begin
         $display("FAIL write_no_read: got rd_cycles=%0d miso=%h want 0/0000", rd_hi, miso_cap);
         n_bad++;
      end
   endtask

   task automatic test_read();
      int dv0 = dv_cnt;
      logic [15:0] f = {4'd2, 4'd5, 8'h69};
      cs = 1'b0;
      #HALF;
      clock_bits(f, 0, 8);
      n_cmp++;
      if ({rd_bypass, rx_addr_dv, o_addr, o_cmd, o_debug_stage} !== {2'b11, 4'd5, 4'd2, 2'd2})
      begin
         $display("FAIL read_hdr: got rd=%b adv=%b addr=%0d cmd=%0d stage=%0d want 1 1 5 2 2",
                  rd_bypass, rx_addr_dv, o_addr, o_cmd, o_debug_stage);
         n_bad++;
      end
      clock_bits(f, 8, 8);
      n_cmp++;
      if (miso_cap !== 16'h003C) begin
         $display("FAIL read_miso: got %h want 003c", miso_cap); n_bad++;
      end
      #HALF;
      cs = 1'b1;
      #100;
      n_cmp++;
      if (dv_cnt - dv0 !== 1 || o_payload !== 8'h69) begin
         $display("FAIL read_done: got dv=%0d payload=%h want 1/69", dv_cnt - dv0, o_payload);
         n_bad++;
      end
      n_cmp++;
      if ({rd_bypass, rx_addr_dv, miso} !== 3'b000) begin
         $display("FAIL read_cs_clear: got %b want 000", {rd_bypass, rx_addr_dv, miso});
         n_bad++;
      end
   endtask

   task automatic test_abort();
      int dv0 = dv_cnt;
      cs = 1'b0;
      #HALF;
      clock_bits({4'd1, 4'd6, 8'h11}, 0, 10);
      #HALF;
      cs = 1'b1;
      #100;
      n_cmp++;
      if (dv_cnt - dv0 !== 0 || o_payload !== 8'h69) begin
         $display("FAIL abort_no_dv: got dv=%0d payload=%h want 0/69", dv_cnt - dv0, o_payload);
         n_bad++;
      end
      n_cmp++;
      if ({rd_bypass, rx_addr_dv, o_debug_stage, o_bit_rx_cnt_debug} !== 9'd0) begin
         $display("FAIL abort_clear: got rd=%b adv=%b stage=%0d cnt=%0d want 0",
                  rd_bypass, rx_addr_dv, o_debug_stage, o_bit_rx_cnt_debug);
         n_bad++;
      end
      run_frame({4'd1, 4'd7, 8'hFF});
      n_cmp++;
      if (dv_cnt - dv0 !== 1 || {o_cmd, o_addr, o_payload} !== 16'h17FF) begin
         $display("FAIL abort_next_frame: got dv=%0d fields=%h want 1/17ff",
                  dv_cnt - dv0, {o_cmd, o_addr, o_payload});
         n_bad++;
      end
   endtask

   task automatic test_back_to_back();
      int dv0 = dv_cnt;
      cs = 1'b0;
      #HALF;
      clock_bits({4'd1, 4'd2, 8'h5A}, 0, 16);
      #HALF;
      cs = 1'b1;
      #(4 * HALF);
      n_cmp++;
      if (dv_cnt - dv0 !== 1 || {o_cmd, o_addr, o_payload} !== 16'h125A) begin
         $display("FAIL b2b_first: got dv=%0d fields=%h want 1/125a",
                  dv_cnt - dv0, {o_cmd, o_addr, o_payload});
         n_bad++;
      end
      run_frame({4'd0, 4'd15, 8'h81});
      n_cmp++;
      if (dv_cnt - dv0 !== 2 || {o_cmd, o_addr, o_payload} !== 16'h0F81) begin
         $display("FAIL b2b_second: got dv=%0d fields=%h want 2/0f81",
                  dv_cnt - dv0, {o_cmd, o_addr, o_payload});
         n_bad++;
      end
   endtask

   task automatic test_mid_reset();
      int dv0 = dv_cnt;
      logic [15:0] f = {4'd1, 4'd9, 8'h33};
      cs = 1'b0;
      #HALF;
      clock_bits(f, 0, 12);
      rst_n = 1'b0;
      #30;
      n_cmp++;
      if ({o_cmd, o_addr, o_payload, rx_addr_dv, rd_bypass, miso} !== 19'd0) begin
         $display("FAIL midrst_fields: got %h want 0",
                  {o_cmd, o_addr, o_payload, rx_addr_dv, rd_bypass, miso});
         n_bad++;
      end
      n_cmp++;
      if ({o_shift_reg_debug, o_bit_rx_cnt_debug, o_debug_stage} !== 23'd0) begin
         $display("FAIL midrst_debug: got %h want 0",
                  {o_shift_reg_debug, o_bit_rx_cnt_debug, o_debug_stage});
         n_bad++;
      end
      #50;
      rst_n = 1'b1;
      #100;
      // cs is still low from the abandoned frame: these bits must be ignored
      clock_bits(f, 12, 4);
      n_cmp++;
      if (dv_cnt - dv0 !== 0 || o_debug_stage !== 2'd0 || o_bit_rx_cnt_debug !== 5'd0) begin
         $display("FAIL midrst_wait_cs: got dv=%0d stage=%0d cnt=%0d want 0/0/0",
                  dv_cnt - dv0, o_debug_stage, o_bit_rx_cnt_debug);
         n_bad++;
      end
      #HALF;
      cs = 1'b1;
      #(2 * HALF);
      run_frame({4'd2, 4'd5, 8'hC3});
      n_cmp++;
      if (dv_cnt - dv0 !== 1 || {o_cmd, o_addr, o_payload} !== 16'h25C3
          || miso_cap !== 16'h003C) begin
         $display("FAIL midrst_next_frame: got dv=%0d fields=%h miso=%h want 1/25c3/003c",
                  dv_cnt - dv0, {o_cmd, o_addr, o_payload}, miso_cap);
         n_bad++;
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_abort();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
